// File: rtl/clic_tx_pkg.sv
// Shared types for the CLIC core-facing transmitter: FSM states, the
// arbitration candidate record and the ordering rule used at every merge point.
package clic_tx_pkg;

  // Candidate fields are sized for up to 1024 sources and 8-bit levels.
  localparam int CandIdW  = 10;
  localparam int CandLvlW = 8;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    OFFER = 2'd1,
    KILL  = 2'd2
  } state_e;

  typedef struct packed {
    logic                vld;
    logic [CandIdW-1:0]  id;
    logic [CandLvlW-1:0] lvl;
    logic [1:0]          priv;
    logic                shv;
  } cand_t;

  // True when a should be preferred over b: higher level wins, lower id breaks ties.
  function automatic logic cand_better(input cand_t a, input cand_t b);
    if (!a.vld) return 1'b0;
    if (!b.vld) return 1'b1;
    if (a.lvl != b.lvl) return a.lvl > b.lvl;
    return a.id < b.id;
  endfunction

endpackage

// File: rtl/clic_lane_max.sv
// Combinational reduction of one scan chunk to its best candidate.
// Zero latency; no flow control.
module clic_lane_max
  import clic_tx_pkg::*;
#(
  parameter int Lanes = 8
) (
  input  cand_t cands [Lanes],
  output cand_t win
);

  always_comb begin
    win = cands[0];
    for (int i = 1; i < Lanes; i++) begin
      if (cand_better(cands[i], win)) win = cands[i];
    end
  end

endmodule

// File: rtl/clic_irq_tx.sv
// CLIC transmitter: time-multiplexed scan of pending sources, offers the winner
// to the core after one full scan (P cycles); held until ready or kill-ack.
module clic_irq_tx
  import clic_tx_pkg::*;
#(
  parameter int NumSrc    = 256,
  parameter int ScanLanes = 8,
  parameter int LevelW    = 8,
  parameter int SrcW      = $clog2(NumSrc)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumSrc-1:0]        pend_i,
  input  logic [NumSrc-1:0]        ie_i,
  input  logic [NumSrc*LevelW-1:0] level_i,
  input  logic [NumSrc-1:0]        shv_i,
  input  logic [NumSrc*2-1:0]      priv_i,
  input  logic [LevelW-1:0]        thresh_i,
  output logic                     irq_valid_o,
  input  logic                     irq_ready_i,
  output logic [SrcW-1:0]          irq_id_o,
  output logic [LevelW-1:0]        irq_level_o,
  output logic [1:0]               irq_priv_o,
  output logic                     irq_shv_o,
  output logic                     kill_req_o,
  input  logic                     kill_ack_i,
  output logic                     claim_valid_o,
  output logic [SrcW-1:0]          claim_id_o
);

  localparam int Period = NumSrc / ScanLanes;
  localparam int CntW   = $clog2(Period);
  localparam int LaneW  = $clog2(ScanLanes);

  state_e          state;
  logic [CntW-1:0] cnt;
  cand_t           best;
  cand_t           lane_c [ScanLanes];
  cand_t           chunk_win;
  cand_t           merged;

  logic [LevelW-1:0] lvl_arr  [NumSrc];
  logic [1:0]        priv_arr [NumSrc];

  for (genvar k = 0; k < NumSrc; k++) begin : g_src
    assign lvl_arr[k]  = level_i[k*LevelW +: LevelW];
    assign priv_arr[k] = priv_i[k*2 +: 2];
  end

  // Source id of lane l in the current chunk is {cnt, l}.
  for (genvar l = 0; l < ScanLanes; l++) begin : g_lane
    logic [SrcW-1:0] sid;
    assign sid       = {cnt, LaneW'(l)};
    assign lane_c[l] = '{vld:  pend_i[sid] & ie_i[sid],
                         id:   CandIdW'(sid),
                         lvl:  CandLvlW'(lvl_arr[sid]),
                         priv: priv_arr[sid],
                         shv:  shv_i[sid]};
  end

  clic_lane_max #(
    .Lanes(ScanLanes)
  ) u_lane_max (
    .cands(lane_c),
    .win  (chunk_win)
  );

  logic last_chunk;
  logic win_above_thresh;
  logic win_preempts;
  logic offered_elig;
  logic offered_lvl_ok;
  logic kill_cond;

  assign merged           = cand_better(chunk_win, best) ? chunk_win : best;
  assign last_chunk       = (cnt == CntW'(Period - 1));
  assign win_above_thresh = merged.vld && (merged.lvl > CandLvlW'(thresh_i));
  assign win_preempts     = last_chunk && merged.vld && (merged.lvl > CandLvlW'(irq_level_o));
  assign offered_elig     = pend_i[irq_id_o] & ie_i[irq_id_o];
  assign offered_lvl_ok   = lvl_arr[irq_id_o] > thresh_i;
  assign kill_cond        = !offered_elig || !offered_lvl_ok || win_preempts;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= SCAN;
      cnt           <= '0;
      best          <= '0;
      irq_valid_o   <= 1'b0;
      irq_id_o      <= '0;
      irq_level_o   <= '0;
      irq_priv_o    <= '0;
      irq_shv_o     <= 1'b0;
      kill_req_o    <= 1'b0;
      claim_valid_o <= 1'b0;
      claim_id_o    <= '0;
    end else begin
      claim_valid_o <= 1'b0;
      // The scan keeps running in every state; exits below restart it at chunk 0.
      cnt  <= last_chunk ? '0 : cnt + 1'b1;
      best <= last_chunk ? '0 : merged;
      case (state)
        SCAN: begin
          if (last_chunk && win_above_thresh) begin
            irq_valid_o <= 1'b1;
            irq_id_o    <= merged.id[SrcW-1:0];
            irq_level_o <= merged.lvl[LevelW-1:0];
            irq_priv_o  <= merged.priv;
            irq_shv_o   <= merged.shv;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (irq_ready_i) begin
            claim_valid_o <= 1'b1;
            claim_id_o    <= irq_id_o;
            irq_valid_o   <= 1'b0;
            cnt           <= '0;
            best          <= '0;
            state         <= SCAN;
          end else if (kill_cond) begin
            kill_req_o <= 1'b1;
            state      <= KILL;
          end
        end
        KILL: begin
          if (irq_ready_i || kill_ack_i) begin
            claim_valid_o <= irq_ready_i;
            if (irq_ready_i) claim_id_o <= irq_id_o;
            irq_valid_o <= 1'b0;
            kill_req_o  <= 1'b0;
            cnt         <= '0;
            best        <= '0;
            state       <= SCAN;
          end
        end
        default: begin
          irq_valid_o <= 1'b0;
          kill_req_o  <= 1'b0;
          state       <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clic_irq_tx.sv
// Directed bench for clic_irq_tx: offer latency, ordering, threshold, kill paths, reset.
module tb_clic_irq_tx;

  localparam int NumSrc = 256;
  localparam int LevelW = 8;
  localparam int SrcW   = 8;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NumSrc-1:0]        pend_i;
  logic [NumSrc-1:0]        ie_i;
  logic [NumSrc*LevelW-1:0] level_i;
  logic [NumSrc-1:0]        shv_i;
  logic [NumSrc*2-1:0]      priv_i;
  logic [LevelW-1:0]        thresh_i;
  logic                     irq_valid_o;
  logic                     irq_ready_i;
  logic [SrcW-1:0]          irq_id_o;
  logic [LevelW-1:0]        irq_level_o;
  logic [1:0]               irq_priv_o;
  logic                     irq_shv_o;
  logic                     kill_req_o;
  logic                     kill_ack_i;
  logic                     claim_valid_o;
  logic [SrcW-1:0]          claim_id_o;

  int checks = 0;
  int errors = 0;

  clic_irq_tx dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pend_i       (pend_i),
    .ie_i         (ie_i),
    .level_i      (level_i),
    .shv_i        (shv_i),
    .priv_i       (priv_i),
    .thresh_i     (thresh_i),
    .irq_valid_o  (irq_valid_o),
    .irq_ready_i  (irq_ready_i),
    .irq_id_o     (irq_id_o),
    .irq_level_o  (irq_level_o),
    .irq_priv_o   (irq_priv_o),
    .irq_shv_o    (irq_shv_o),
    .kill_req_o   (kill_req_o),
    .kill_ack_i   (kill_ack_i),
    .claim_valid_o(claim_valid_o),
    .claim_id_o   (claim_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic clear_inputs;
    pend_i      = '0;
    ie_i        = '0;
    level_i     = '0;
    shv_i       = '0;
    priv_i      = '0;
    thresh_i    = '0;
    irq_ready_i = 1'b0;
    kill_ack_i  = 1'b0;
  endtask

  task automatic set_src(input int k, input logic [7:0] lvl, input logic [1:0] prv, input logic sh);
    pend_i[k]            = 1'b1;
    ie_i[k]              = 1'b1;
    level_i[k*LevelW +: LevelW] = lvl;
    priv_i[k*2 +: 2]     = prv;
    shv_i[k]             = sh;
  endtask

  // Release lands between edges so the next edge is the first cnt==0 cycle.
  task automatic do_reset;
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({irq_valid_o, kill_req_o, claim_valid_o, irq_id_o, irq_level_o, irq_priv_o, irq_shv_o, claim_id_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b kill=%b claim=%b id=%0d lvl=%0d required all zero",
               irq_valid_o, kill_req_o, claim_valid_o, irq_id_o, irq_level_o);
    end
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic test_single_source;
    clear_inputs();
    set_src(37, 8'd5, 2'd2, 1'b1);
    do_reset();
    tick(5);
    irq_ready_i = 1'b1;
    tick(1);
    irq_ready_i = 1'b0;
    checks++;
    if (claim_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_without_valid claim=%b required 0", claim_valid_o);
    end
    tick(25);
    checks++;
    if (irq_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_early valid=%b at cycle 31 required 0", irq_valid_o);
    end
    tick(1);
    checks++;
    if ({irq_valid_o, irq_id_o, irq_level_o, irq_priv_o, irq_shv_o} !== {1'b1, 8'd37, 8'd5, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_offer valid=%b id=%0d lvl=%0d priv=%0d shv=%b required 1/37/5/2/1",
               irq_valid_o, irq_id_o, irq_level_o, irq_priv_o, irq_shv_o);
    end
    kill_ack_i = 1'b1;
    tick(1);
    kill_ack_i = 1'b0;
    checks++;
    if ({irq_valid_o, kill_req_o, claim_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL ack_outside_kill valid=%b kill=%b claim=%b required 1/0/0",
               irq_valid_o, kill_req_o, claim_valid_o);
    end
    // Withdrawal and ready in the same cycle: ready must win.
    irq_ready_i = 1'b1;
    pend_i[37]  = 1'b0;
    tick(1);
    irq_ready_i = 1'b0;
    checks++;
    if ({claim_valid_o, claim_id_o, irq_valid_o, kill_req_o} !== {1'b1, 8'd37, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_claim claim=%b id=%0d valid=%b kill=%b required 1/37/0/0",
               claim_valid_o, claim_id_o, irq_valid_o, kill_req_o);
    end
    tick(1);
    checks++;
    if (claim_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL claim_one_cycle claim=%b required 0", claim_valid_o);
    end
  endtask

  task automatic test_tie_threshold;
    int seen;
    clear_inputs();
    set_src(200, 8'd9, 2'd3, 1'b0);
    set_src(10, 8'd9, 2'd1, 1'b0);
    thresh_i = 8'd8;
    do_reset();
    tick(32);
    checks++;
    if ({irq_valid_o, irq_id_o, irq_level_o, irq_priv_o} !== {1'b1, 8'd10, 8'd9, 2'd1}) begin
      errors++;
      $display("FAIL tie_offer valid=%b id=%0d lvl=%0d priv=%0d required 1/10/9/1",
               irq_valid_o, irq_id_o, irq_level_o, irq_priv_o);
    end
    irq_ready_i = 1'b1;
    tick(1);
    irq_ready_i = 1'b0;
    thresh_i    = 8'd9;
    checks++;
    if ({claim_valid_o, claim_id_o} !== {1'b1, 8'd10}) begin
      errors++;
      $display("FAIL tie_claim claim=%b id=%0d required 1/10", claim_valid_o, claim_id_o);
    end
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (irq_valid_o) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL thresh_block valid_cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_level_zero;
    int seen;
    clear_inputs();
    set_src(5, 8'd0, 2'd0, 1'b0);
    do_reset();
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      tick(1);
      if (irq_valid_o) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL level_zero valid_cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_preempt;
    int waited;
    clear_inputs();
    set_src(10, 8'd9, 2'd0, 1'b0);
    do_reset();
    tick(32);
    checks++;
    if ({irq_valid_o, irq_id_o} !== {1'b1, 8'd10}) begin
      errors++;
      $display("FAIL preempt_first valid=%b id=%0d required 1/10", irq_valid_o, irq_id_o);
    end
    set_src(3, 8'd12, 2'd3, 1'b1);
    waited = 0;
    while (!kill_req_o && waited < 64) begin
      tick(1);
      waited++;
    end
    checks++;
    if ({kill_req_o, irq_valid_o, irq_id_o, irq_level_o} !== {1'b1, 1'b1, 8'd10, 8'd9}) begin
      errors++;
      $display("FAIL preempt_kill kill=%b valid=%b id=%0d lvl=%0d after %0d cycles required 1/1/10/9 within 64",
               kill_req_o, irq_valid_o, irq_id_o, irq_level_o, waited);
    end
    kill_ack_i = 1'b1;
    tick(1);
    kill_ack_i = 1'b0;
    checks++;
    if ({irq_valid_o, kill_req_o, claim_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL preempt_ack valid=%b kill=%b claim=%b required 0/0/0",
               irq_valid_o, kill_req_o, claim_valid_o);
    end
    tick(31);
    checks++;
    if (irq_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL preempt_gap valid=%b at 31 cycles required 0", irq_valid_o);
    end
    tick(1);
    checks++;
    if ({irq_valid_o, irq_id_o, irq_level_o, irq_priv_o, irq_shv_o} !== {1'b1, 8'd3, 8'd12, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL preempt_reoffer valid=%b id=%0d lvl=%0d priv=%0d shv=%b required 1/3/12/3/1",
               irq_valid_o, irq_id_o, irq_level_o, irq_priv_o, irq_shv_o);
    end
  endtask

  task automatic test_withdraw_ready_ack;
    int seen;
    clear_inputs();
    set_src(10, 8'd9, 2'd0, 1'b0);
    do_reset();
    tick(32);
    pend_i[10] = 1'b0;
    tick(1);
    checks++;
    if ({kill_req_o, irq_valid_o, irq_id_o} !== {1'b1, 1'b1, 8'd10}) begin
      errors++;
      $display("FAIL withdraw_kill kill=%b valid=%b id=%0d required 1/1/10",
               kill_req_o, irq_valid_o, irq_id_o);
    end
    irq_ready_i = 1'b1;
    kill_ack_i  = 1'b1;
    tick(1);
    irq_ready_i = 1'b0;
    kill_ack_i  = 1'b0;
    checks++;
    if ({claim_valid_o, claim_id_o, irq_valid_o, kill_req_o} !== {1'b1, 8'd10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ready_ack_claim claim=%b id=%0d valid=%b kill=%b required 1/10/0/0",
               claim_valid_o, claim_id_o, irq_valid_o, kill_req_o);
    end
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      tick(1);
      if (irq_valid_o) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL no_reoffer valid_cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_reset_mid_kill;
    clear_inputs();
    set_src(10, 8'd9, 2'd2, 1'b1);
    do_reset();
    tick(32);
    pend_i[10] = 1'b0;
    tick(1);
    checks++;
    if (kill_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup_kill kill=%b required 1", kill_req_o);
    end
    clear_inputs();
    set_src(7, 8'd4, 2'd1, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({irq_valid_o, kill_req_o, claim_valid_o, irq_id_o, irq_level_o} !== '0) begin
      errors++;
      $display("FAIL rst_async valid=%b kill=%b claim=%b id=%0d lvl=%0d required all zero",
               irq_valid_o, kill_req_o, claim_valid_o, irq_id_o, irq_level_o);
    end
    tick(2);
    rst_i = 1'b0;
    tick(31);
    checks++;
    if (irq_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_early valid=%b at 31 cycles required 0", irq_valid_o);
    end
    tick(1);
    checks++;
    if ({irq_valid_o, irq_id_o, irq_level_o} !== {1'b1, 8'd7, 8'd4}) begin
      errors++;
      $display("FAIL rst_reoffer valid=%b id=%0d lvl=%0d required 1/7/4",
               irq_valid_o, irq_id_o, irq_level_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_tie_threshold();
    test_level_zero();
    test_preempt();
    test_withdraw_ready_ack();
    test_reset_mid_kill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clic_irq_tx.md
# clic_irq_tx

Core-facing transmitter of the CLIC: arbitrates the pending and enabled interrupt sources and offers the winner to the core's CLIC interrupt port. The offer uses a valid/ready handshake with a kill-request side channel. Arbitration is a time-multiplexed scan of `ScanLanes` sources per cycle, which keeps the 256-source comparison off the critical path. The block sits between the CLIC register file (pending/enable/level/shv/priv per source) and the CVA6 core.

## Interface
- `NumSrc`, 256: number of interrupt sources; power of two, divisible by `ScanLanes`.
- `ScanLanes`, 8: sources compared per scan cycle; power of two.
- `LevelW`, 8: interrupt level width.
- `SrcW`, `$clog2(NumSrc)`: id width (derived).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `pend_i` in NumSrc: per-source pending.
- `ie_i` in NumSrc: per-source enable.
- `level_i` in NumSrc*LevelW: per-source level; source k occupies bits [k*LevelW +: LevelW].
- `shv_i` in NumSrc: per-source selective-hardware-vectoring flag.
- `priv_i` in NumSrc*2: per-source target privilege.
- `thresh_i` in LevelW: effective threshold (max of mintthresh and current interrupt level).
- `irq_valid_o` out 1: interrupt offered.
- `irq_ready_i` in 1: core accepts the offer.
- `irq_id_o` out SrcW: offered id.
- `irq_level_o` out LevelW: offered level.
- `irq_priv_o` out 2: offered privilege.
- `irq_shv_o` out 1: offered shv.
- `kill_req_o` out 1: request that the core drop the offer.
- `kill_ack_i` in 1: core has dropped the offer.
- `claim_valid_o` out 1: one-cycle pulse on an accepted handshake.
- `claim_id_o` out SrcW: accepted id; the register file uses it to clear edge-triggered pending.

## Operation
- **Eligibility.** A source is eligible when `pend_i & ie_i`.
- **Ordering.** Higher level wins; on equal level, the lower id wins.
- **Offer condition.** A winner is offered only if its level > `thresh_i`. A level-0 source therefore never wins.
- **Scan.** Counter `cnt` runs 0..NumSrc/ScanLanes-1 and wraps. In each cycle, lanes `cnt*ScanLanes..+ScanLanes-1` are reduced and merged into registered `best_{vld,id,lvl}`. `best` is cleared when `cnt==0` is loaded. Inputs are sampled live; no snapshot is taken.
- **States:**
  - **SCAN.**
    - On the last chunk, if the merged result is valid and above threshold: latch id/level/priv/shv into the output registers, go to OFFER, set `cnt=0`.
    - Otherwise wrap and rescan.
  - **OFFER.** `irq_valid_o=1`. The outputs are held stable, and background scanning continues.
    - `irq_ready_i`: pulse claim, drop valid, go to SCAN, set `cnt=0`.
    - Otherwise, if the offered source is no longer eligible, its live level ≤ `thresh_i`, or a completed background scan finds `best_lvl > irq_level_o`: go to KILL.
  - **KILL.** `irq_valid_o=1`, `kill_req_o=1`, outputs stable.
    - `irq_ready_i`: claim, go to SCAN.
    - Else `kill_ack_i`: go to SCAN, no claim.
    - Else stay in KILL.
    - On either exit, `cnt=0` and `kill_req_o` drops.
- **Priority rules.**
  - `irq_ready_i` has priority over every kill condition and over `kill_ack_i` in the same cycle.
  - `kill_ack_i` outside KILL is ignored.
  - `irq_ready_i` while `irq_valid_o=0` is ignored.

## Timing
- **Reset.** All outputs are 0, state is SCAN, `cnt=0`, `best` cleared. Reset asserted mid-OFFER or mid-KILL drops valid/kill asynchronously, with no claim.
- **Scan period.** P = NumSrc/ScanLanes (32 by default).
- **Pend-to-valid latency.** For a source eligible from the cycle where `cnt==0`, `irq_valid_o` rises exactly P cycles later. The worst case from any eligibility edge is 2P-1 cycles.
- **Claim.** `claim_valid_o` is asserted in the cycle after the handshake cycle, for one cycle. `irq_valid_o` is 0 in that same cycle.
- **Kill.** A kill condition detected in cycle t gives `kill_req_o=1` from t+1.
- **Preemption.** A strictly higher-level source that becomes eligible during OFFER causes `kill_req_o` at most 2P cycles later.
- **Back-to-back offers.** The minimum gap between two offers is P cycles, because the scan restarts after every exit.

## Structure
- Package `clic_tx_pkg`:
  - `state_e` {SCAN, OFFER, KILL};
  - `cand_t` struct {vld, id, lvl, priv, shv};
  - function `cand_better(a, b)` implementing the ordering rule.
- Sub-module `clic_lane_max`: a combinational reduction of `ScanLanes` candidates to one `cand_t` using `cand_better`. The top level instantiates it once and merges its result with `best` via the same function.

## Test plan
- **Single source.** Src 37 level 5, `thresh_i=0`, eligible from `cnt==0` → valid at +32 cycles with id 37, level 5. Ready → claim pulse with id 37 next cycle.
- **Tie and threshold.** Srcs 10 and 200 both level 9 → id 10 offered. Then `thresh_i=9` → no offer for ≥3 full scans.
- **Preemption.** During an OFFER of id 10 level 9, src 3 rises with level 12 → `kill_req_o` within 64 cycles. `kill_ack_i` → valid drops with no claim, then id 3 is offered 32 cycles later.
- **Source withdrawn.** Clear `pend_i[10]` during OFFER → `kill_req_o` next cycle.
- **Ready and kill-ack together.** `irq_ready_i` and `kill_ack_i` in the same KILL cycle → claim id 10, no second offer of id 10 while it is not pending.
- **Reset.** Assert `rst_i` mid-KILL → all outputs 0 immediately. After release, eligible src 7 is offered 32 cycles after the first `cnt==0`.
